doodle_sprite_ctrl: RTL and testbench

Sequencer for the three 32x32 doodle sprite ROMs (basic, holiday, nightmare). It turns the VGA scan position and the doodle's screen position into one shared ROM read address and muxes the selected skin's ROM output. It returns a pipelined palette index plus a hit flag to the colour mapper. Skin, flip and position changes are committed only at frame boundaries, so a frame never tears between skins.

---
 rtl/doodle_sprite_ctrl.sv | 168 ++++++++++++++++
 tb/tb_doodle_sprite_ctrl.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/doodle_sprite_ctrl.sv
// doodle_sprite_ctrl
// Turns the VGA scan position and the doodle's screen position into one
// shared read address for the three 32x32 doodle sprite ROMs. It then muxes
// the selected skin's ROM output into a registered palette index plus a hit
// flag for the colour mapper. Skin, flip and position are committed only on
// frame_start, so a frame never tears between skins.
//
// Ports
//   Clk, Reset_n                     clock, async active-low reset
//   frame_start                      one-cycle pulse at start of vblank
//   skin_req_valid, skin_req[1:0]    skin change request (3 = reserved)
//   flip_req                         requested horizontal mirror
//   doodle_x, doodle_y [9:0]         requested sprite top-left coordinate
//   pix_valid, DrawX, DrawY [9:0]    scan position, valid qualifier
//   rom_addr [15:0]                  shared ROM read address (registered)
//   rom_*_data [7:0]                 ROM outputs (1-cycle registered read)
//   pix_out_valid, pix_hit           result valid / opaque sprite pixel
//   pix_index [7:0]                  palette index, 0 when not a hit
//   active_skin [1:0]                skin currently in use
module doodle_sprite_ctrl #(
    parameter int unsigned W = 32,
    parameter int unsigned H = 32
) (
    input  logic        Clk,
    input  logic        Reset_n,
    input  logic        frame_start,
    input  logic        skin_req_valid,
    input  logic [1:0]  skin_req,
    input  logic        flip_req,
    input  logic [9:0]  doodle_x,
    input  logic [9:0]  doodle_y,
    input  logic        pix_valid,
    input  logic [9:0]  DrawX,
    input  logic [9:0]  DrawY,
    output logic [15:0] rom_addr,
    input  logic [7:0]  rom_basic_data,
    input  logic [7:0]  rom_holiday_data,
    input  logic [7:0]  rom_night_data,
    output logic        pix_out_valid,
    output logic        pix_hit,
    output logic [7:0]  pix_index,
    output logic [1:0]  active_skin
);

    localparam int unsigned CW = (W > 1) ? $clog2(W) : 1;
    localparam int unsigned DW = 11;
    localparam int unsigned AW = 16;

    typedef enum logic {
        S_IDLE    = 1'b0,
        S_PENDING = 1'b1
    } skin_state_t;

    skin_state_t state;
    logic [1:0]  pend_skin;
    logic        flip_r;
    logic [9:0]  pos_x_r;
    logic [9:0]  pos_y_r;

    logic          req_ok_c;
    logic [DW-1:0] dx_c;
    logic [DW-1:0] dy_c;
    logic          inside_c;
    logic [CW-1:0] col_c;
    logic [AW-1:0] addr_c;
    logic [7:0]    night_c;
    logic [7:0]    raw_c;
    logic          hit_c;

    logic          v1, in1, v2, in2;
    logic [1:0]    sk1, sk2;

    assign req_ok_c = skin_req_valid && (skin_req != 2'd3);

    // Skin request FSM and frame registers; a request coinciding with
    // frame_start is captured for the next frame, not this one.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state       <= S_IDLE;
            pend_skin   <= 2'd0;
            active_skin <= 2'd0;
            flip_r      <= 1'b0;
            pos_x_r     <= 10'd0;
            pos_y_r     <= 10'd0;
        end else begin
            if (frame_start) begin
                flip_r  <= flip_req;
                pos_x_r <= doodle_x;
                pos_y_r <= doodle_y;
                if (state == S_PENDING) begin
                    active_skin <= pend_skin;
                end
            end
            if (req_ok_c) begin
                pend_skin <= skin_req;
                state     <= S_PENDING;
            end else if (frame_start) begin
                state <= S_IDLE;
            end
        end
    end

    // Stage 0: sprite-relative offset; the 11th bit flags a negative offset
    // so positions near the right/bottom edge never wrap.
    always_comb begin
        dx_c     = {1'b0, DrawX} - {1'b0, pos_x_r};
        dy_c     = {1'b0, DrawY} - {1'b0, pos_y_r};
        inside_c = pix_valid
                   && !dx_c[DW-1] && (dx_c < DW'(W))
                   && !dy_c[DW-1] && (dy_c < DW'(H));
        // W is a power of two, so W-1-dx is the bitwise inverse of dx.
        col_c    = dx_c[CW-1:0] ^ {CW{flip_r}};
        addr_c   = inside_c ? AW'((32'(dy_c) << CW) | 32'(col_c)) : AW'(0);
    end

    // Stage 1: ROM address plus tags for the pixel.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            rom_addr <= 16'd0;
            v1       <= 1'b0;
            in1      <= 1'b0;
            sk1      <= 2'd0;
        end else begin
            rom_addr <= addr_c;
            v1       <= pix_valid;
            in1      <= inside_c;
            sk1      <= active_skin;
        end
    end

    // Stage 2: tags shadow the ROM's internal read register.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            v2  <= 1'b0;
            in2 <= 1'b0;
            sk2 <= 2'd0;
        end else begin
            v2  <= v1;
            in2 <= in1;
            sk2 <= sk1;
        end
    end

    // Skin mux; the nightmare ROM holds 3-bit entries.
    always_comb begin
        night_c = rom_night_data & 8'h07;
        case (sk2)
            2'd0:    raw_c = rom_basic_data;
            2'd1:    raw_c = rom_holiday_data;
            default: raw_c = night_c;
        endcase
        hit_c = v2 && in2 && (raw_c != 8'd0);
    end

    // Stage 3: registered result to the colour mapper.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            pix_out_valid <= 1'b0;
            pix_hit       <= 1'b0;
            pix_index     <= 8'd0;
        end else begin
            pix_out_valid <= v2;
            pix_hit       <= hit_c;
            pix_index     <= hit_c ? raw_c : 8'd0;
        end
    end

endmodule

// File: tb/tb_doodle_sprite_ctrl.sv
// Self-checking bench for doodle_sprite_ctrl: ROM models, a reference model
// of the frame/skin registers and a scoreboard queue of expected pixels.
module tb_doodle_sprite_ctrl;

    localparam int W = 32;
    localparam int H = 32;

    logic        Clk;
    logic        Reset_n;
    logic        frame_start;
    logic        skin_req_valid;
    logic [1:0]  skin_req;
    logic        flip_req;
    logic [9:0]  doodle_x, doodle_y;
    logic        pix_valid;
    logic [9:0]  DrawX, DrawY;
    logic [15:0] rom_addr;
    logic [7:0]  rom_basic_data, rom_holiday_data, rom_night_data;
    logic        pix_out_valid, pix_hit;
    logic [7:0]  pix_index;
    logic [1:0]  active_skin;

    doodle_sprite_ctrl #(.W(W), .H(H)) dut (
        .Clk(Clk), .Reset_n(Reset_n), .frame_start(frame_start),
        .skin_req_valid(skin_req_valid), .skin_req(skin_req), .flip_req(flip_req),
        .doodle_x(doodle_x), .doodle_y(doodle_y), .pix_valid(pix_valid),
        .DrawX(DrawX), .DrawY(DrawY), .rom_addr(rom_addr),
        .rom_basic_data(rom_basic_data), .rom_holiday_data(rom_holiday_data),
        .rom_night_data(rom_night_data), .pix_out_valid(pix_out_valid),
        .pix_hit(pix_hit), .pix_index(pix_index), .active_skin(active_skin)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    // ROM models with a one-cycle registered read.
    logic [7:0] rom_b [65536];
    logic [7:0] rom_h [65536];
    logic [7:0] rom_n [65536];

    always @(posedge Clk) begin
        rom_basic_data   <= rom_b[rom_addr];
        rom_holiday_data <= rom_h[rom_addr];
        rom_night_data   <= rom_n[rom_addr];
    end

    typedef struct packed {
        logic       v;
        logic       h;
        logic [7:0] idx;
    } exp_t;

    exp_t q[$];

    int n_cmp = 0;
    int n_err = 0;

    // Reference model state.
    logic [1:0] m_skin, m_pend;
    logic       m_pv, m_flip;
    logic [9:0] m_px, m_py;

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_skin = 2'd0; m_pend = 2'd0; m_pv = 1'b0; m_flip = 1'b0;
        m_px = 10'd0; m_py = 10'd0;
        q.delete();
        q.push_back('0);
        q.push_back('0);
    endtask

    task automatic cycle(input logic fs, input logic rv, input logic [1:0] rs,
                         input logic fl, input logic [9:0] qx, input logic [9:0] qy,
                         input logic pv, input logic [9:0] sx, input logic [9:0] sy);
        int   dxi, dyi, col, ea;
        logic ins;
        logic [7:0] raw;
        exp_t e;
        @(negedge Clk);
        frame_start = fs; skin_req_valid = rv; skin_req = rs; flip_req = fl;
        doodle_x = qx; doodle_y = qy; pix_valid = pv; DrawX = sx; DrawY = sy;
        dxi = int'(sx) - int'(m_px);
        dyi = int'(sy) - int'(m_py);
        ins = pv && dxi >= 0 && dxi < W && dyi >= 0 && dyi < H;
        col = m_flip ? (W - 1 - dxi) : dxi;
        ea  = ins ? (dyi * W + col) : 0;
        case (m_skin)
            2'd0:    raw = rom_b[ea];
            2'd1:    raw = rom_h[ea];
            default: raw = rom_n[ea] & 8'h07;
        endcase
        e.v   = pv;
        e.h   = ins && (raw != 8'd0);
        e.idx = e.h ? raw : 8'd0;
        q.push_back(e);
        if (fs) begin
            m_px = qx; m_py = qy; m_flip = fl;
            if (m_pv) begin
                m_skin = m_pend;
                m_pv   = 1'b0;
            end
        end
        if (rv && rs != 2'd3) begin
            m_pend = rs;
            m_pv   = 1'b1;
        end
        @(posedge Clk);
        #1;
        check("rom_addr", rom_addr, 16'(ea));
        check("active_skin", 16'(active_skin), 16'(m_skin));
        e = q.pop_front();
        check("pix_out_valid", 16'(pix_out_valid), 16'(e.v));
        check("pix_hit", 16'(pix_hit), 16'(e.h));
        check("pix_index", 16'(pix_index), 16'(e.idx));
    endtask

    task automatic pix(input logic [9:0] sx, input logic [9:0] sy);
        cycle(1'b0, 1'b0, 2'd0, 1'b0, 10'd0, 10'd0, 1'b1, sx, sy);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++)
            cycle(1'b0, 1'b0, 2'd0, 1'b0, 10'd0, 10'd0, 1'b0, 10'd0, 10'd0);
    endtask

    task automatic frame(input logic fl, input logic [9:0] qx, input logic [9:0] qy);
        cycle(1'b1, 1'b0, 2'd0, fl, qx, qy, 1'b0, 10'd0, 10'd0);
    endtask

    task automatic req(input logic [1:0] s);
        cycle(1'b0, 1'b1, s, 1'b0, 10'd0, 10'd0, 1'b0, 10'd0, 10'd0);
    endtask

    task automatic check_zero_outputs(input string tag);
        check({tag, "_rom_addr"}, rom_addr, 16'd0);
        check({tag, "_valid"}, 16'(pix_out_valid), 16'd0);
        check({tag, "_hit"}, 16'(pix_hit), 16'd0);
        check({tag, "_index"}, 16'(pix_index), 16'd0);
        check({tag, "_skin"}, 16'(active_skin), 16'd0);
    endtask

    initial begin
        for (int i = 0; i < 65536; i++) begin
            rom_b[i] = 8'(i * 3 + 1);
            rom_h[i] = 8'(i * 5 + 7);
            rom_n[i] = 8'(i * 13 + 5);
        end
        rom_b[5]  = 8'h00;
        rom_h[5]  = 8'h00;
        rom_n[10] = 8'hFB;
        rom_n[11] = 8'h07;
        rom_n[12] = 8'h08;

        Reset_n = 1'b0; frame_start = 1'b0; skin_req_valid = 1'b0; skin_req = 2'd0;
        flip_req = 1'b0; doodle_x = 10'd0; doodle_y = 10'd0; pix_valid = 1'b0;
        DrawX = 10'd0; DrawY = 10'd0;
        repeat (2) @(posedge Clk);
        #1;
        check_zero_outputs("reset");
        Reset_n = 1'b1;
        model_reset();

        // Basic skin, no flip: corners of the sprite and just outside it.
        frame(1'b0, 10'd100, 10'd200);
        pix(10'd100, 10'd200);
        pix(10'd131, 10'd231);
        pix(10'd132, 10'd200);
        pix(10'd99,  10'd200);
        pix(10'd105, 10'd200);
        pix(10'd100, 10'd232);
        idle(2);

        // Flipped.
        frame(1'b1, 10'd100, 10'd200);
        pix(10'd100, 10'd205);
        pix(10'd132, 10'd205);
        pix(10'd131, 10'd205);
        idle(2);

        // Mid-frame request for nightmare takes effect at the next frame.
        req(2'd2);
        pix(10'd110, 10'd200);
        frame(1'b0, 10'd100, 10'd200);
        pix(10'd110, 10'd200);
        pix(10'd111, 10'd200);
        pix(10'd112, 10'd200);
        idle(2);

        // Last request wins; coincident request deferred; reserved ignored.
        req(2'd1);
        req(2'd0);
        frame(1'b0, 10'd100, 10'd200);
        cycle(1'b1, 1'b1, 2'd1, 1'b0, 10'd100, 10'd200, 1'b0, 10'd0, 10'd0);
        pix(10'd120, 10'd210);
        frame(1'b0, 10'd100, 10'd200);
        req(2'd3);
        frame(1'b0, 10'd100, 10'd200);
        pix(10'd105, 10'd200);
        pix(10'd106, 10'd201);

        // Pixels in flight across a skin commit keep the old skin.
        req(2'd2);
        pix(10'd110, 10'd200);
        cycle(1'b1, 1'b0, 2'd0, 1'b0, 10'd100, 10'd200, 1'b1, 10'd111, 10'd200);
        pix(10'd111, 10'd200);
        idle(2);

        // Near the right screen edge: negative offsets must not wrap.
        frame(1'b0, 10'd1010, 10'd990);
        pix(10'd5,    10'd995);
        pix(10'd1023, 10'd995);
        pix(10'd1015, 10'd1021);
        pix(10'd1015, 10'd989);
        pix(10'd1010, 10'd1000);
        idle(2);

        // Random stream with occasional frame commits and requests.
        for (int i = 0; i < 60; i++) begin
            cycle((i % 13) == 12, ($urandom_range(0, 7) == 0), 2'($urandom_range(0, 3)),
                  1'($urandom_range(0, 1)), 10'd100, 10'd200,
                  ($urandom_range(0, 3) != 0),
                  10'(90 + $urandom_range(0, 50)), 10'(195 + $urandom_range(0, 45)));
        end

        // Reset pulse mid-stream: outputs drop immediately, nothing in flight survives.
        @(negedge Clk);
        Reset_n = 1'b0;
        pix_valid = 1'b1;
        #1;
        check_zero_outputs("async_reset");
        @(posedge Clk);
        #1;
        check_zero_outputs("held_reset");
        Reset_n = 1'b1;
        model_reset();
        for (int i = 0; i < 12; i++)
            pix(10'($urandom_range(0, 40)), 10'($urandom_range(0, 40)));
        idle(3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
